// File: rtl/ifetch.sv
// Instruction fetch stage: drives the fetch PC to a 1-cycle-latency memory, pairs
// returned words with their PC and buffers them in a 2-entry FIFO toward decode.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc4_o,
    output logic        valid_o,
    input  logic        ready_i
);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] fifo_instr_q [2];
    logic [31:0] fifo_pc_q    [2];

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occupancy;

    assign valid_o   = (count_q != 2'd0);
    assign pop       = valid_o & ready_i;
    assign push      = inflight_q & ~redirect_i;
    // Entries the FIFO will hold once the outstanding response lands; a new
    // request is only issued if its own response is guaranteed a free slot.
    assign occupancy = {1'b0, count_q} - {2'b00, pop} + {2'b00, inflight_q};
    assign issue     = ~redirect_i & (occupancy <= 3'd1);

    assign imem_pc_o = pc_q;
    assign instr_o   = fifo_instr_q[rd_ptr_q];
    assign pc_o      = fifo_pc_q[rd_ptr_q];
    assign pc4_o     = pc_o + 32'd4;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        if (redirect_i) begin
            pc_d     = redirect_pc_i & ~32'h3;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (issue) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            if (push) begin
                fifo_instr_q[wr_ptr_q] <= imem_instr_i;
                fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: the expected decode stream is the sequential
// address run from the latest reset/redirect target, checked as entries are consumed.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr = '0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] instr_o, pc_o, pc4_o;
    logic        valid_o;
    logic        ready_i = 1'b0;

    logic        rst2_n = 1'b0;
    logic [31:0] imem2_pc;
    logic [31:0] imem2_instr = '0;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect2_pc = '0;
    logic [31:0] instr2, pc2, pc42;
    logic        valid2;
    logic        ready2 = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t        sbq[$];
    logic [31:0] push_pc = '0;

    always #5 clk = ~clk;

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_pc_o(imem_pc), .imem_instr_i(imem_instr),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .instr_o(instr_o), .pc_o(pc_o), .pc4_o(pc4_o), .valid_o(valid_o), .ready_i(ready_i)
    );

    ifetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst2_n), .imem_pc_o(imem2_pc), .imem_instr_i(imem2_instr),
        .redirect_i(redirect2), .redirect_pc_i(redirect2_pc),
        .instr_o(instr2), .pc_o(pc2), .pc4_o(pc42), .valid_o(valid2), .ready_i(ready2)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        imem_instr  <= memf(imem_pc);
        imem2_instr <= memf(imem2_pc);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic topup();
        exp_t e;
        while (sbq.size() < 4) begin
            e.pc    = push_pc;
            e.instr = memf(push_pc);
            sbq.push_back(e);
            push_pc = push_pc + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] pc);
        sbq.delete();
        push_pc = pc & ~32'h3;
        topup();
    endtask

    // One clock cycle of stimulus; expectations are rebuilt right at the edge
    // that consumes the reset or redirect, after that cycle's pop was checked.
    task automatic cyc(input bit rst, input bit rdy, input bit redir, input logic [31:0] rpc);
        @(negedge clk);
        rst_n         = ~rst;
        ready_i       = rdy;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        @(posedge clk);
        if (rst) restart(32'h0000_0000);
        else if (redir) restart(rpc);
        topup();
        #1;
    endtask

    // Monitor: compares the buffer head against the scoreboard front each cycle
    always begin
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n === 1'b1) begin
            chk("imem_align", {30'd0, imem_pc[1:0]}, 32'd0);
            if (valid_o === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sbq[0];
                    chk("head_pc", pc_o, e.pc);
                    chk("head_instr", instr_o, e.instr);
                    chk("head_pc4", pc4_o, e.pc + 32'd4);
                    if (ready_i) void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_pc;
        logic [31:0] wexp [4];
        int wi;
        bit r, rd;

        // Wrap-around instance: RESET_PC near the top of the address space
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0; wexp[3] = 32'h4;
        ready2 = 1'b1;
        @(negedge clk); rst2_n = 1'b0;
        @(negedge clk);
        #1;
        chk("wrap_rst_pc", imem2_pc, 32'hFFFF_FFF8);
        chk("wrap_rst_valid", {31'd0, valid2}, 32'd0);
        rst2_n = 1'b1;
        wi = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (valid2 && wi < 4) begin
                chk("wrap_pc", pc2, wexp[wi]);
                chk("wrap_instr", instr2, memf(wexp[wi]));
                chk("wrap_pc4", pc42, wexp[wi] + 32'd4);
                wi++;
            end
        end
        chk("wrap_pops", wi, 4);

        // Reset state and first-fetch latency
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_pc4", pc4_o, 32'd4);
        chk("rst_imem_pc", imem_pc, 32'd0);
        cyc(0, 1, 0, 0);
        chk("lat_not_yet", {31'd0, valid_o}, 32'd0);
        cyc(0, 1, 0, 0);
        chk("lat_first_valid", {31'd0, valid_o}, 32'd1);
        chk("lat_first_pc", pc_o, 32'd0);
        for (int i = 1; i < 6; i++) begin
            cyc(0, 1, 0, 0);
            chk("stream_valid", {31'd0, valid_o}, 32'd1);
            chk("stream_pc", pc_o, 32'(4 * i));
        end

        // Decode stall: fetch stops once both slots are spoken for
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk("stall_valid", {31'd0, valid_o}, 32'd1);
            if (i == 1) held_pc = imem_pc;
            if (i == 4) chk("stall_pc_hold", imem_pc, held_pc);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 0, 0);
            chk("resume_valid", {31'd0, valid_o}, 32'd1);
        end

        // Redirect while full and stalled
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h40);
        chk("redir_t1_valid", {31'd0, valid_o}, 32'd0);
        cyc(0, 1, 0, 0);
        chk("redir_t2_valid", {31'd0, valid_o}, 32'd0);
        cyc(0, 1, 0, 0);
        chk("redir_t3_valid", {31'd0, valid_o}, 32'd1);
        chk("redir_t3_pc", pc_o, 32'h40);
        chk("redir_t3_instr", instr_o, 32'h110);

        // Misaligned redirect coincident with a pop, then back-to-back redirects
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'h43);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("redir43_pc", pc_o, 32'h40);
        for (int i = 0; i < 2; i++) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 32'h80);
        cyc(0, 1, 1, 32'hC0);
        cyc(0, 1, 0, 0);
        chk("b2b_t2_valid", {31'd0, valid_o}, 32'd0);
        cyc(0, 1, 0, 0);
        chk("b2b_valid", {31'd0, valid_o}, 32'd1);
        chk("b2b_pc", pc_o, 32'hC0);

        // Reset mid-stream with the buffer full
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("midrst_valid", {31'd0, valid_o}, 32'd0);
        chk("midrst_imem_pc", imem_pc, 32'd0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("midrst_first_pc", pc_o, 32'd0);
        chk("midrst_first_valid", {31'd0, valid_o}, 32'd1);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            r  = ($urandom_range(0, 149) == 0);
            rd = ($urandom_range(0, 3) != 0);
            cyc(r, rd, ($urandom_range(0, 19) == 0), $urandom);
        end
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
